// File: rtl/ct_cp0_rst_inv_ctrl.sv
// CP0 responder for the IFU reset-invalidate handshake: walks every icache set
// through the array arbiter, then reports done. Optional BHT stage: CT_CP0_RST_BHT_INV_EN.
module ct_cp0_rst_inv_ctrl #(
    parameter int INDEX_WIDTH = 8,
    parameter int PC_WIDTH    = 40
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    input  logic                   ifu_cp0_rst_inv_req,
    input  logic                   ifu_cp0_rst_mrvbr_req,
    input  logic                   ifu_xx_sync_reset,
    input  logic [PC_WIDTH-1:0]    pad_yy_rvbr,
    input  logic                   inv_arb_gnt,
`ifdef CT_CP0_RST_BHT_INV_EN
    input  logic                   bht_cp0_inv_done,
    output logic                   cp0_bht_inv_req,
`endif
    output logic                   cp0_inv_arb_req,
    output logic                   cp0_inv_wen,
    output logic [INDEX_WIDTH-1:0] cp0_inv_index,
    output logic                   cp0_ifu_rst_inv_done,
    output logic [PC_WIDTH-1:0]    cp0_ifu_rvbr,
    output logic                   cp0_inv_busy
);

`ifdef CT_CP0_RST_BHT_INV_EN
    typedef enum logic [1:0] {IDLE, WALK, BHT, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
`endif

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
    // The reset vector is word aligned; the mask drops the two low pad bits.
    localparam logic [PC_WIDTH-1:0]    RVBR_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    state_t                 state;
    logic [INDEX_WIDTH-1:0] index;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= IDLE;
            index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_cp0_rst_inv_req) begin
                        state <= WALK;
                        index <= '0;
                    end
                end
                WALK: begin
                    if (inv_arb_gnt) begin
                        index <= index + 1'b1;
                        if (index == LAST_IDX) begin
`ifdef CT_CP0_RST_BHT_INV_EN
                            state <= BHT;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef CT_CP0_RST_BHT_INV_EN
                BHT: begin
                    if (bht_cp0_inv_done)
                        state <= DONE;
                end
`endif
                DONE: begin
                    // A fresh request wins over the IFU leaving reset.
                    if (ifu_cp0_rst_inv_req) begin
                        state <= WALK;
                        index <= '0;
                    end else if (!ifu_xx_sync_reset) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b)
            cp0_ifu_rvbr <= '0;
        else if (ifu_cp0_rst_mrvbr_req)
            cp0_ifu_rvbr <= pad_yy_rvbr & RVBR_MASK;
    end

    assign cp0_inv_arb_req      = (state == WALK);
    assign cp0_inv_wen          = (state == WALK) && inv_arb_gnt;
    assign cp0_inv_index        = index;
    assign cp0_ifu_rst_inv_done = (state == DONE);
    assign cp0_inv_busy         = (state != IDLE);
`ifdef CT_CP0_RST_BHT_INV_EN
    assign cp0_bht_inv_req      = (state == BHT);
`endif

endmodule

// File: tb/tb_ct_cp0_rst_inv_ctrl.sv
// Scoreboard bench for ct_cp0_rst_inv_ctrl; also builds with CT_CP0_RST_BHT_INV_EN.
module tb_ct_cp0_rst_inv_ctrl;
    localparam int IW = 8;
    localparam int PW = 40;
    localparam int NSETS = 1 << IW;
`ifdef CT_CP0_RST_BHT_INV_EN
    localparam int BHT_EXTRA = 6;
`else
    localparam int BHT_EXTRA = 0;
`endif

    logic          forever_cpuclk = 1'b0;
    logic          cpurst_b;
    logic          inv_req, mrvbr_req, sync_reset, gnt;
    logic [PW-1:0] pad;
    logic          arb_req, wen, done, busy;
    logic [IW-1:0] index;
    logic [PW-1:0] rvbr;
`ifdef CT_CP0_RST_BHT_INV_EN
    logic          bht_req, bht_done;
`endif

    int            total = 0;
    int            bad = 0;
    int            exp_q[$];
    int            grants = 0;
    logic [PW-1:0] exp_rvbr = '0;

    ct_cp0_rst_inv_ctrl #(.INDEX_WIDTH(IW), .PC_WIDTH(PW)) dut (
        .forever_cpuclk       (forever_cpuclk),
        .cpurst_b             (cpurst_b),
        .ifu_cp0_rst_inv_req  (inv_req),
        .ifu_cp0_rst_mrvbr_req(mrvbr_req),
        .ifu_xx_sync_reset    (sync_reset),
        .pad_yy_rvbr          (pad),
        .inv_arb_gnt          (gnt),
`ifdef CT_CP0_RST_BHT_INV_EN
        .bht_cp0_inv_done     (bht_done),
        .cp0_bht_inv_req      (bht_req),
`endif
        .cp0_inv_arb_req      (arb_req),
        .cp0_inv_wen          (wen),
        .cp0_inv_index        (index),
        .cp0_ifu_rst_inv_done (done),
        .cp0_ifu_rvbr         (rvbr),
        .cp0_inv_busy         (busy)
    );

    initial forever #5 forever_cpuclk = ~forever_cpuclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must consume the next expected set index.
    initial begin
        logic done_q;
        done_q = 1'b0;
        forever begin
            @(negedge forever_cpuclk);
            if (cpurst_b) begin
                if (wen) begin
                    if (exp_q.size() == 0) begin
                        chk("wen_unexpected", 64'(wen), 64'(0));
                    end else begin
                        chk("wen_index", 64'(index), 64'(exp_q.pop_front()));
                        chk("wen_needs_gnt", 64'(gnt), 64'(1));
                    end
                    grants++;
                end
                if (done && !done_q) begin
                    chk("done_grants", 64'(grants), 64'(NSETS));
                    chk("done_all_sets", 64'(exp_q.size()), 64'(0));
                end
                done_q = done;
            end else begin
                done_q = 1'b0;
            end
        end
    end

`ifdef CT_CP0_RST_BHT_INV_EN
    initial begin
        int cnt;
        bht_done = 1'b0;
        cnt = 0;
        forever begin
            @(negedge forever_cpuclk);
            cnt = bht_req ? cnt + 1 : 0;
            if (cnt == 5) begin
                @(posedge forever_cpuclk); #1 bht_done = 1'b1;
                @(posedge forever_cpuclk); #1 bht_done = 1'b0;
                cnt = 0;
            end
        end
    end
`endif

    // Issue one request cycle; the model expects every set, in ascending order.
    task automatic issue(input logic mr, input logic [PW-1:0] p, input logic inv);
        @(posedge forever_cpuclk); #1;
        inv_req   = inv;
        mrvbr_req = mr;
        pad       = p;
        if (inv) begin
            exp_q.delete();
            for (int i = 0; i < NSETS; i++) exp_q.push_back(i);
            grants = 0;
        end
        if (mr) exp_rvbr = p - (p % 4);
        @(posedge forever_cpuclk); #1;
        inv_req   = 1'b0;
        mrvbr_req = 1'b0;
    endtask

    // mode 0: grant always, 1: alternating grant, 2: random grant plus a stray request.
    task automatic wait_done(input int mode, output int n);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge forever_cpuclk);
            n++;
            if (done) break;
            @(posedge forever_cpuclk); #1;
            case (mode)
                0: gnt = 1'b1;
                1: gnt = ~gnt;
                default: gnt = 1'($urandom_range(0, 1));
            endcase
            inv_req = (mode == 2 && n == 60);
        end
        chk("done_seen", 64'(done), 64'(1));
        @(posedge forever_cpuclk); #1 inv_req = 1'b0;
    endtask

    task automatic leave_reset_state();
        @(posedge forever_cpuclk); #1 sync_reset = 1'b0;
        @(posedge forever_cpuclk); #1;
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        sync_reset = 1'b1;
    endtask

    initial begin
        int n;
        logic bad_flag;
        cpurst_b = 1'b0; inv_req = 1'b0; mrvbr_req = 1'b0;
        sync_reset = 1'b1; gnt = 1'b0; pad = '0;
        repeat (3) @(posedge forever_cpuclk);
        #1;
        chk("rst_arb_req", 64'(arb_req), 64'(0));
        chk("rst_wen", 64'(wen), 64'(0));
        chk("rst_index", 64'(index), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rvbr", 64'(rvbr), 64'(0));
        cpurst_b = 1'b1;

        // Basic walk with rvbr latch and grant tied high.
        gnt = 1'b1;
        issue(1'b1, 40'hFF_FFFF_FFFF, 1'b1);
        chk("rvbr_latch", 64'(rvbr), 64'(exp_rvbr));
        chk("walk_busy", 64'(busy), 64'(1));
        chk("walk_arb_req", 64'(arb_req), 64'(1));
        wait_done(0, n);
        chk("basic_latency", 64'(n), 64'(NSETS + 1 + BHT_EXTRA));
        repeat (3) begin
            @(negedge forever_cpuclk);
            chk("done_held", 64'(done), 64'(1));
        end

        // Re-request in DONE with rvbr untouched, random grants, stray request mid-walk.
        issue(1'b0, '0, 1'b1);
        chk("rereq_done_drop", 64'(done), 64'(0));
        chk("rereq_index", 64'(index), 64'(0));
        chk("rereq_busy", 64'(busy), 64'(1));
        chk("rvbr_hold", 64'(rvbr), 64'(exp_rvbr));
        wait_done(2, n);
        leave_reset_state();

        // Alternating grant.
        gnt = 1'b0;
        issue(1'b0, '0, 1'b1);
        wait_done(1, n);
        leave_reset_state();

        // rvbr latch alone never starts a walk.
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, {8'($urandom), $urandom}, 1'b0);
            chk("rvbr_only", 64'(rvbr), 64'(exp_rvbr));
            chk("rvbr_only_busy", 64'(busy), 64'(0));
        end

        // Asynchronous reset part-way through a walk.
        gnt = 1'b1;
        issue(1'b0, '0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            @(negedge forever_cpuclk);
            if (index == IW'(100)) break;
        end
        chk("midwalk_index", 64'(index), 64'(100));
        #1 cpurst_b = 1'b0;
        exp_rvbr = '0;
        #1;
        chk("arst_arb_req", 64'(arb_req), 64'(0));
        chk("arst_wen", 64'(wen), 64'(0));
        chk("arst_index", 64'(index), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_rvbr", 64'(rvbr), 64'(exp_rvbr));
        exp_q.delete();
        grants = 0;
        @(posedge forever_cpuclk); #1 cpurst_b = 1'b1;
        bad_flag = 1'b0;
        repeat (20) begin
            @(negedge forever_cpuclk);
            if (done || busy) bad_flag = 1'b1;
        end
        chk("arst_no_done", 64'(bad_flag), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
